vga_timer_bcd: RTL and testbench
================================

// Module: vga_timer_bcd
// PURPOSE
//   Game countdown timer producing four BCD digit codes (MM:SS) for the VGA
//   digit decoders. Each dig_* output drives the 4-bit num input of one
//   num-to-segment-colour decoder instance.
//   Code 4'd10 is the dash glyph in that decoder. It is shown while idle.
// PARAMETERS
//   TICK_CYCLES  100_000_000  clk cycles per 1 s decrement (>=2)
//   START_MIN    2            preset minutes, 0..99
//   START_SEC    0            preset seconds, 0..59
// PORTS
//   clk            in   1  system clock, all state on rising edge
//   rst_n          in   1  asynchronous active-low reset
//   start          in   1  1-cycle pulse: load preset and run
//   pause          in   1  1-cycle pulse: toggle RUN <-> PAUSED
//   stop           in   1  1-cycle pulse: abort to IDLE
//   dig_mt         out  4  minutes tens digit code
//   dig_mo         out  4  minutes ones digit code
//   dig_st         out  4  seconds tens digit code
//   dig_so         out  4  seconds ones digit code
//   running        out  1  1 while state is RUN
//   expired        out  1  1 while state is DONE
//   expire_pulse   out  1  1-cycle pulse on entry to DONE
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, prescaler=0, time register=preset.
//   - All dig_*=4'd10; running, expired, expire_pulse = 0.
// - States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
// - Command priority per cycle: stop > start > pause. Lower-priority commands
//   in the same cycle are ignored.
// - stop: any state -> IDLE; prescaler cleared; time reloaded with preset.
// - start: any state -> RUN; time=preset; prescaler=0. This restarts the
//   count if already running. If preset=00:00, start -> DONE directly.
// - pause: RUN -> PAUSED, or PAUSED -> RUN. Ignored in IDLE and DONE.
//   The prescaler value is held while PAUSED and resumes from it.
// - Prescaler:
//   - Increments only in RUN.
//   - On the edge where prescaler==TICK_CYCLES-1, it wraps to 0 and time
//     decrements by 1 s.
//   - First decrement is TICK_CYCLES edges after the edge that samples start.
// - BCD decrement, each field 4 bits:
//   - so: 0 -> 9 with borrow, else so-1.
//   - st (on borrow): 0 -> 5 with borrow, else st-1.
//   - mo (on borrow): 0 -> 9 with borrow, else mo-1.
//   - mt (on borrow): decrements. It never underflows because 00:00 stops
//     the count.
// - Expiry: the tick that yields 00:00 moves the state to DONE on that same
//   edge, with expire_pulse=1 for exactly that cycle.
// - DONE: dig_* = 0,0,0,0 and expired=1, held until start or stop.
// - Digit outputs:
//   - IDLE: all 4'd10.
//   - RUN/PAUSED/DONE: the time register.
//   - Digits update on the same edge as the state/time change.
// - running=1 only in RUN. expired=1 only in DONE.
// - Reset mid-operation returns immediately to the reset values.
// TESTING (TICK_CYCLES=4, START_MIN=1, START_SEC=0)
//   1. rst_n low during RUN -> dig_*=10,10,10,10; running=0; expired=0 at once.
//   2. start at edge k -> 0,1,0,0 at k+1; 0,0,5,9 at k+4 (borrow chain).
//   3. start, run 240 cycles -> 0,0,0,0 at k+240; expire_pulse 1 cycle;
//      expired stays 1 with digits frozen.
//   4. pause after 2 RUN cycles, hold 10 cycles, pause -> next decrement
//      exactly 2 RUN cycles after resume.
//   5. start+stop same cycle -> IDLE, dashes. start+pause in RUN -> restart
//      at 01:00.
//   6. START_MIN=0, START_SEC=0: start -> DONE next edge, expire_pulse=1.

Source files
------------

// File: rtl/vga_timer_bcd.sv
// Game countdown timer: MM:SS held as four BCD digits, decremented once per
// TICK_CYCLES clocks while running, shown as dashes (code 10) while idle.
module vga_timer_bcd #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int START_MIN   = 2,
    parameter int START_SEC   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] dig_mt,
    output logic [3:0] dig_mo,
    output logic [3:0] dig_st,
    output logic [3:0] dig_so,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam int              PW       = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]   LAST     = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]      P_MT     = 4'(START_MIN / 10);
    localparam logic [3:0]      P_MO     = 4'(START_MIN % 10);
    localparam logic [3:0]      P_ST     = 4'(START_SEC / 10);
    localparam logic [3:0]      P_SO     = 4'(START_SEC % 10);
    localparam logic            P_ZERO   = (START_MIN == 0) && (START_SEC == 0);
    localparam logic [3:0]      DASH     = 4'd10;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [3:0]    mt, mo, st, so;
    logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
    logic          pulse_nx;

    // Next-state logic. Commands resolve stop > start > pause; the prescaler
    // only advances on RUN cycles that carry no command, so a pause or resume
    // edge neither consumes nor loses a prescaler count.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        mt_nx    = mt;
        mo_nx    = mo;
        st_nx    = st;
        so_nx    = so;
        pulse_nx = 1'b0;

        if (stop) begin
            state_nx = IDLE;
            presc_nx = '0;
            {mt_nx, mo_nx, st_nx, so_nx} = {P_MT, P_MO, P_ST, P_SO};
        end else if (start) begin
            presc_nx = '0;
            {mt_nx, mo_nx, st_nx, so_nx} = {P_MT, P_MO, P_ST, P_SO};
            state_nx = P_ZERO ? DONE : RUN;
            pulse_nx = P_ZERO;
        end else if (pause && state == RUN) begin
            state_nx = PAUSED;
        end else if (pause && state == PAUSED) begin
            state_nx = RUN;
        end else if (state == RUN) begin
            if (presc == LAST) begin
                presc_nx = '0;
                if (so == 4'd0) begin
                    so_nx = 4'd9;
                    if (st == 4'd0) begin
                        st_nx = 4'd5;
                        if (mo == 4'd0) begin
                            mo_nx = 4'd9;
                            mt_nx = mt - 4'd1;
                        end else begin
                            mo_nx = mo - 4'd1;
                        end
                    end else begin
                        st_nx = st - 4'd1;
                    end
                end else begin
                    so_nx = so - 4'd1;
                end
                if ({mt_nx, mo_nx, st_nx, so_nx} == 16'h0000) begin
                    state_nx = DONE;
                    pulse_nx = 1'b1;
                end
            end else begin
                presc_nx = presc + 1'b1;
            end
        end
    end

    // Internal state plus outputs registered from the next-state values, so
    // digits and flags change on the same edge as the state and time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            presc        <= '0;
            mt           <= P_MT;
            mo           <= P_MO;
            st           <= P_ST;
            so           <= P_SO;
            dig_mt       <= DASH;
            dig_mo       <= DASH;
            dig_st       <= DASH;
            dig_so       <= DASH;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_nx;
            presc        <= presc_nx;
            mt           <= mt_nx;
            mo           <= mo_nx;
            st           <= st_nx;
            so           <= so_nx;
            if (state_nx == IDLE) begin
                dig_mt <= DASH;
                dig_mo <= DASH;
                dig_st <= DASH;
                dig_so <= DASH;
            end else begin
                dig_mt <= mt_nx;
                dig_mo <= mo_nx;
                dig_st <= st_nx;
                dig_so <= so_nx;
            end
            running      <= (state_nx == RUN);
            expired      <= (state_nx == DONE);
            expire_pulse <= pulse_nx;
        end
    end

endmodule

// File: tb/tb_vga_timer_bcd.sv
// Directed bench for vga_timer_bcd: main instance 01:00 @4 cycles/s, plus a
// 00:00 preset instance and a 10:00 @2 cycles/s instance for minute borrow.
module tb_vga_timer_bcd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic stop = 1'b0;

    logic [3:0] a_mt, a_mo, a_st, a_so;
    logic       a_run, a_exp, a_pulse;
    logic [3:0] z_mt, z_mo, z_st, z_so;
    logic       z_run, z_exp, z_pulse;
    logic [3:0] t_mt, t_mo, t_st, t_so;
    logic       t_run, t_exp, t_pulse;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timer_bcd #(.TICK_CYCLES(4), .START_MIN(1), .START_SEC(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .dig_mt(a_mt), .dig_mo(a_mo), .dig_st(a_st), .dig_so(a_so),
        .running(a_run), .expired(a_exp), .expire_pulse(a_pulse)
    );

    vga_timer_bcd #(.TICK_CYCLES(4), .START_MIN(0), .START_SEC(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .dig_mt(z_mt), .dig_mo(z_mo), .dig_st(z_st), .dig_so(z_so),
        .running(z_run), .expired(z_exp), .expire_pulse(z_pulse)
    );

    vga_timer_bcd #(.TICK_CYCLES(2), .START_MIN(10), .START_SEC(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .dig_mt(t_mt), .dig_mo(t_mo), .dig_st(t_st), .dig_so(t_so),
        .running(t_run), .expired(t_exp), .expire_pulse(t_pulse)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the given commands for exactly one sampling edge.
    task automatic applyStimulus(input logic s, input logic p, input logic t);
        start = s;
        pause = p;
        stop  = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'hAAAA) begin
            fails++;
            $display("[TB] FAIL reset_digits: got %h want aaaa", {a_mt, a_mo, a_st, a_so});
        end
        checks++;
        if ({a_run, a_exp, a_pulse} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b want 000", {a_run, a_exp, a_pulse});
        end
        step(6);
        checks++;
        if ({a_mt, a_mo, a_st, a_so, a_run} !== 17'h15554) begin
            fails++;
            $display("[TB] FAIL idle_hold: got %h want 15554", {a_mt, a_mo, a_st, a_so, a_run});
        end
    endtask

    task automatic test_countdown;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100 || a_run !== 1'b1) begin
            fails++;
            $display("[TB] FAIL start_load: got %h run=%b want 0100 run=1",
                     {a_mt, a_mo, a_st, a_so}, a_run);
        end
        step(3);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL before_first_tick: got %h want 0100", {a_mt, a_mo, a_st, a_so});
        end
        step(1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0059) begin
            fails++;
            $display("[TB] FAIL borrow_chain: got %h want 0059", {a_mt, a_mo, a_st, a_so});
        end
        step(4);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0058) begin
            fails++;
            $display("[TB] FAIL second_tick: got %h want 0058", {a_mt, a_mo, a_st, a_so});
        end
    endtask

    task automatic test_pause;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if ({a_run, a_exp} !== 2'b00 || {a_mt, a_mo, a_st, a_so} !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL pause_enter: got %h run=%b want 0100 run=0",
                     {a_mt, a_mo, a_st, a_so}, a_run);
        end
        step(10);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL pause_hold: got %h want 0100", {a_mt, a_mo, a_st, a_so});
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (a_run !== 1'b1) begin
            fails++;
            $display("[TB] FAIL resume: running got %b want 1", a_run);
        end
        step(1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL resume_early: got %h want 0100", {a_mt, a_mo, a_st, a_so});
        end
        step(1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0059) begin
            fails++;
            $display("[TB] FAIL resume_tick: got %h want 0059", {a_mt, a_mo, a_st, a_so});
        end
    endtask

    task automatic test_commands;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'hAAAA || {a_run, a_exp} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL start_stop: got %h run=%b want aaaa run=0",
                     {a_mt, a_mo, a_st, a_so}, a_run);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(4);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'hAAAA || a_run !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_pause: got %h run=%b want aaaa run=0",
                     {a_mt, a_mo, a_st, a_so}, a_run);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100 || a_run !== 1'b1) begin
            fails++;
            $display("[TB] FAIL start_pause: got %h run=%b want 0100 run=1",
                     {a_mt, a_mo, a_st, a_so}, a_run);
        end
        step(3);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL restart_presc: got %h want 0100", {a_mt, a_mo, a_st, a_so});
        end
        step(1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0059) begin
            fails++;
            $display("[TB] FAIL restart_tick: got %h want 0059", {a_mt, a_mo, a_st, a_so});
        end
    endtask

    task automatic test_minute_borrow;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checks++;
        if ({t_mt, t_mo, t_st, t_so} !== 16'h1000) begin
            fails++;
            $display("[TB] FAIL ten_load: got %h want 1000", {t_mt, t_mo, t_st, t_so});
        end
        step(2);
        checks++;
        if ({t_mt, t_mo, t_st, t_so} !== 16'h0959) begin
            fails++;
            $display("[TB] FAIL ten_borrow: got %h want 0959", {t_mt, t_mo, t_st, t_so});
        end
    endtask

    task automatic test_expiry;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(239);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0001 || {a_run, a_exp, a_pulse} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL last_second: got %h flags=%b want 0001 flags=100",
                     {a_mt, a_mo, a_st, a_so}, {a_run, a_exp, a_pulse});
        end
        step(1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0000 || {a_run, a_exp, a_pulse} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL expire: got %h flags=%b want 0000 flags=011",
                     {a_mt, a_mo, a_st, a_so}, {a_run, a_exp, a_pulse});
        end
        step(1);
        checks++;
        if ({a_run, a_exp, a_pulse} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL pulse_width: got flags=%b want 010", {a_run, a_exp, a_pulse});
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        step(8);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0000 || {a_run, a_exp, a_pulse} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL done_hold: got %h flags=%b want 0000 flags=010",
                     {a_mt, a_mo, a_st, a_so}, {a_run, a_exp, a_pulse});
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'hAAAA || a_exp !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_stop: got %h exp=%b want aaaa exp=0",
                     {a_mt, a_mo, a_st, a_so}, a_exp);
        end
    endtask

    task automatic test_zero_preset;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checks++;
        if ({z_mt, z_mo, z_st, z_so} !== 16'h0000 || {z_run, z_exp, z_pulse} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL zero_start: got %h flags=%b want 0000 flags=011",
                     {z_mt, z_mo, z_st, z_so}, {z_run, z_exp, z_pulse});
        end
        step(1);
        checks++;
        if ({z_run, z_exp, z_pulse} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL zero_pulse: got flags=%b want 010", {z_run, z_exp, z_pulse});
        end
    endtask

    task automatic test_reset_mid_run;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(5);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'hAAAA || {a_run, a_exp, a_pulse} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL async_reset: got %h flags=%b want aaaa flags=000",
                     {a_mt, a_mo, a_st, a_so}, {a_run, a_exp, a_pulse});
        end
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(3);
        checks++;
        if ({a_mt, a_mo, a_st, a_so} !== 16'h0100) begin
            fails++;
            $display("[TB] FAIL post_reset_presc: got %h want 0100", {a_mt, a_mo, a_st, a_so});
        end
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        #1;
        test_reset;
        test_countdown;
        test_pause;
        test_commands;
        test_minute_borrow;
        test_expiry;
        test_zero_preset;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
